// File: rtl/alu_decoder_md.sv
// ALU decoder for RV32I with an iterative RV32M multiply/divide sequencer.
// The decode outputs are combinational. The sequencer does one bit per cycle and
// hands its result over with a valid/ready handshake.
module alu_decoder_md #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CTRL_W   = 4,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  input  logic              opb5,
  input  logic [1:0]        ALUOp,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              is_muldiv,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  output logic [XLEN-1:0]   md_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         f3_q, f3_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d;
  logic [XLEN-1:0]    mb_q, mb_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    md_result_q, md_result_d;

  logic [3:0]         alu_code;
  logic               is_md;
  logic               a_signed, b_signed, sa_in, sb_in;
  logic [XLEN:0]      mul_sum, rem_sh, div_diff;
  logic [ACC_W-1:0]   prod;
  logic [XLEN-1:0]    quot, rem;
  logic               last_iter;

  // Instruction decode to ALU control code; M ops override the base table
  always_comb begin
    alu_code = 4'b0000;
    is_md    = ENABLE_M && (ALUOp == 2'b10) && opb5 && funct7b0;
    case (ALUOp)
      2'b00: alu_code = 4'b0010;
      2'b01: alu_code = 4'b0110;
      2'b10: begin
        case (funct3)
          3'b000:  alu_code = (opb5 && funct7b5) ? 4'b0110 : 4'b0010;
          3'b111:  alu_code = 4'b0000;
          3'b110:  alu_code = 4'b0001;
          3'b100:  alu_code = 4'b0011;
          3'b010:  alu_code = 4'b0111;
          3'b011:  alu_code = 4'b1000;
          3'b001:  alu_code = 4'b0100;
          default: alu_code = funct7b5 ? 4'b1001 : 4'b0101;
        endcase
      end
      default: alu_code = 4'b0000;
    endcase
    if (is_md) alu_code = 4'b1111;
  end

  assign ALUControl = CTRL_W'(alu_code);
  assign is_muldiv  = is_md;
  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign md_result  = md_result_q;

  // Datapath helpers: operand signedness, one iteration step, sign-corrected results
  always_comb begin
    a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa_in     = a_signed && src_a[XLEN-1];
    sb_in     = b_signed && src_b[XLEN-1];
    mul_sum   = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    rem_sh    = acc_q[ACC_W-1:XLEN-1];
    div_diff  = rem_sh - {1'b0, mb_q};
    prod      = (sa_q ^ sb_q) ? (~acc_q + ACC_W'(1)) : acc_q;
    quot      = dz_q ? {XLEN{1'b1}}
              : ((sa_q ^ sb_q) ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0]);
    rem       = sa_q ? (~acc_q[ACC_W-1:XLEN] + XLEN'(1)) : acc_q[ACC_W-1:XLEN];
    last_iter = (cnt_q == CNT_W'(XLEN - 1));
  end

  // Sequencer next-state and register updates
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    dz_d        = dz_q;
    mb_d        = mb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    md_result_d = md_result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && is_md) begin
          f3_d    = funct3;
          sa_d    = sa_in;
          sb_d    = sb_in;
          dz_d    = 1'b0;
          mb_d    = sb_in ? (~src_b + XLEN'(1)) : src_b;
          acc_d   = {{XLEN{1'b0}}, (sa_in ? (~src_a + XLEN'(1)) : src_a)};
          cnt_d   = '0;
          state_d = funct3[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) state_d = S_FIN;
      end
      S_DIV: begin
        if ((cnt_q == '0) && (mb_q == '0)) begin
          // Divide by zero: quotient all ones, remainder is the dividend
          acc_d   = {acc_q[XLEN-1:0], {XLEN{1'b1}}};
          dz_d    = 1'b1;
          state_d = S_FIN;
        end else if ((cnt_q == '0) && sa_q && sb_q && (mb_q == XLEN'(1)) &&
                     (acc_q[XLEN-1:0] == {1'b1, {(XLEN-1){1'b0}}})) begin
          // Signed overflow: magnitudes already hold quotient=MIN, remainder=0
          state_d = S_FIN;
        end else begin
          if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) state_d = S_FIN;
        end
      end
      S_FIN: begin
        case (f3_q)
          3'b000:          md_result_d = prod[XLEN-1:0];
          3'b001, 3'b010,
          3'b011:          md_result_d = prod[ACC_W-1:XLEN];
          3'b100, 3'b101:  md_result_d = quot;
          default:         md_result_d = rem;
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      f3_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      dz_q        <= 1'b0;
      mb_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      md_result_q <= '0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      dz_q        <= dz_d;
      mb_q        <= mb_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      md_result_q <= md_result_d;
    end
  end

endmodule
